aes_inv_key_sched: RTL

- Sequential AES-128 inverse key scheduler for the decrypt datapath.
- Accepts the cipher key and expands it forward one round per cycle to reach the round-10 key.
- Then streams round keys in reverse order (10 down to 0) over a valid/ready handshake, undoing one expansion step per accepted key.
- Sits between the key register and the inverse-cipher round core.
- Counterpart of the forward round-key generator.

---
 rtl/aes_pkg.sv | 45 ++++
 rtl/aes_key_g_word.sv | 27 ++
 rtl/aes_inv_key_sched.sv | 120 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 constants and types: S-box, Rcon, key types,
//               and inverse key scheduler state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_key_t;

  localparam int NR = 10;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_expand = 2'd1;
  localparam logic [1:0] c_st_serve  = 2'd2;

  // Element 0 sits in the leftmost byte, so c_sbox[b] is a direct lookup.
  localparam logic [0:255][7:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:15][7:0] c_rcon = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

endpackage
`default_nettype wire

// File: rtl/aes_key_g_word.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_g_word
// Description : Key-schedule G function: RotWord, SubWord, Rcon XOR.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_g_word
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [3:0]  round,
  output logic [31:0] word_out
);

  logic [31:0] w_rot;
  logic [31:0] w_sub;

  assign w_rot = {word_in[23:0], word_in[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign w_sub[8*i +: 8] = c_sbox[w_rot[8*i +: 8]];
  end

  assign word_out = w_sub ^ {c_rcon[round], 24'h0};

endmodule
`default_nettype wire

// File: rtl/aes_inv_key_sched.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_key_sched
// Description : AES-128 inverse key scheduler; expands forward to round 10,
//               then streams round keys 10..0 over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] key_out,
  output logic [3:0]   out_round
);

  localparam logic [3:0] c_last = 4'(NR);

  logic [1:0]   r_state;
  logic [127:0] r_key;
  logic [3:0]   r_rnd;
  logic         r_busy;
  logic         r_valid;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_g_in, w_g_out;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [31:0]  w_p0, w_p1, w_p2, w_p3;
  logic         w_accept;

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;

  // One G instance serves both directions; undoing a step needs G(w3 ^ w2).
  assign w_g_in = (r_state == c_st_serve) ? (w_w3 ^ w_w2) : w_w3;

  aes_key_g_word u_g_word (
    .word_in  (w_g_in),
    .round    (r_rnd),
    .word_out (w_g_out)
  );

  assign w_n0 = w_w0 ^ w_g_out;
  assign w_n1 = w_n0 ^ w_w1;
  assign w_n2 = w_n1 ^ w_w2;
  assign w_n3 = w_n2 ^ w_w3;

  assign w_p3 = w_w3 ^ w_w2;
  assign w_p2 = w_w2 ^ w_w1;
  assign w_p1 = w_w1 ^ w_w0;
  assign w_p0 = w_w0 ^ w_g_out;

  assign w_accept = r_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_key   <= '0;
      r_rnd   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (key_load) begin
            r_key   <= key_in;
            r_rnd   <= 4'd1;
            r_busy  <= 1'b1;
            r_state <= c_st_expand;
          end
        end
        c_st_expand: begin
          r_key <= {w_n0, w_n1, w_n2, w_n3};
          if (r_rnd == c_last) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_state <= c_st_serve;
          end else begin
            r_rnd <= r_rnd + 4'd1;
          end
        end
        c_st_serve: begin
          if (key_load) begin
            r_key   <= key_in;
            r_rnd   <= 4'd1;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_state <= c_st_expand;
          end else if (w_accept) begin
            if (r_rnd == 4'd0) begin
              r_valid <= 1'b0;
              r_state <= c_st_idle;
            end else begin
              r_key <= {w_p0, w_p1, w_p2, w_p3};
              r_rnd <= r_rnd - 4'd1;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign key_out   = r_key;
  assign out_round = r_rnd;

endmodule
`default_nettype wire
